// File: rtl/spi_shiftreg_pkg.sv
// Shared state type, SPI mode encodings and sizing helper for the SPI slave shift register.
package spi_shiftreg_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Bits needed to hold a bit count of 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Edge detector for an oversampled SPI line: optional 2-flop synchronizer (SPI_SHIFTREG_SYNC_EN),
// one-deep history, and pulses for transitions away from (lead) and back to (trail) the idle level.
module spi_edge_detect #(
    parameter bit IdleVal = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic sig,
    output logic lead,
    output logic trail
);

    logic cur;
    logic z_q;

`ifdef SPI_SHIFTREG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= {2{IdleVal}};
        end else begin
            sync_q <= {sync_q[0], sig};
        end
    end

    assign cur = sync_q[1];
`else
    assign cur = sig;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            z_q <= IdleVal;
        end else begin
            z_q <= cur;
        end
    end

    assign lead  = (cur != z_q) && (z_q == IdleVal);
    assign trail = (cur != z_q) && (cur == IdleVal);

endmodule

// File: rtl/spi_shiftreg.sv
// SPI slave shift register oversampled on clk, all four modes, double-buffered transmit word.
// Define SPI_SHIFTREG_SYNC_EN to add 2-flop synchronizers on spi_clk, spi_cs_n and din.
module spi_shiftreg
    import spi_shiftreg_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter bit          CPOL = 1'b0,
    parameter bit          CPHA = 1'b0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         spi_clk,
    input  logic         spi_cs_n,
    input  logic         din,
    output logic         dout,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         busy,
    output logic         underrun,
    output logic         aborted
);

    localparam int unsigned CW         = cnt_width(N);
    localparam logic [1:0]  Mode       = {CPOL, CPHA};
    localparam bit          SampleLead = (Mode == MODE0) || (Mode == MODE2);

    logic clk_lead, clk_trail, cs_fall, cs_rise;
    logic din_s;
    logic sample_edge, shift_edge, start;
    logic [N-1:0] rx_shift;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  tx_q, tx_d;
    logic [N-1:0]  rx_q, rx_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic          shadow_full_q, shadow_full_d;
    logic          dout_q, dout_d;
    logic          rx_valid_q, rx_valid_d;
    logic          underrun_q, underrun_d;
    logic          aborted_q, aborted_d;

    spi_edge_detect #(.IdleVal(CPOL)) u_clk_edge (
        .clk   (clk),
        .nreset(nreset),
        .sig   (spi_clk),
        .lead  (clk_lead),
        .trail (clk_trail)
    );

    // Chip select idles high, so its leading edge is the falling edge.
    spi_edge_detect #(.IdleVal(1'b1)) u_cs_edge (
        .clk   (clk),
        .nreset(nreset),
        .sig   (spi_cs_n),
        .lead  (cs_fall),
        .trail (cs_rise)
    );

`ifdef SPI_SHIFTREG_SYNC_EN
    logic [1:0] din_sync_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            din_sync_q <= 2'b00;
        end else begin
            din_sync_q <= {din_sync_q[0], din};
        end
    end

    assign din_s = din_sync_q[1];
`else
    assign din_s = din;
`endif

    assign sample_edge = SampleLead ? clk_lead : clk_trail;
    assign shift_edge  = SampleLead ? clk_trail : clk_lead;
    assign rx_shift    = {rx_q[N-2:0], din_s};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        rx_data_d     = rx_data_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        dout_d        = dout_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        aborted_d     = 1'b0;
        start         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StActive;
                    start   = 1'b1;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    aborted_d = (cnt_q != '0);
                    cnt_d     = '0;
                end else if (sample_edge) begin
                    rx_d = rx_shift;
                    if (cnt_q == CW'(N - 1)) begin
                        rx_data_d  = rx_shift;
                        rx_valid_d = 1'b1;
                        start      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shift_edge) begin
                    if (CPHA) begin
                        dout_d = tx_q[N-1];
                        tx_d   = {tx_q[N-2:0], 1'b0};
                    end else if (cnt_q != '0) begin
                        // At count 0 this trailing edge closes the previous word; MSB is already out.
                        dout_d = tx_q[N-2];
                        tx_d   = {tx_q[N-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            tx_d          = shadow_full_q ? shadow_q : '0;
            underrun_d    = !shadow_full_q;
            shadow_full_d = 1'b0;
            cnt_d         = '0;
            if (!CPHA) begin
                dout_d = tx_d[N-1];
            end
        end

        // A load in the same cycle as a word start lands in the shadow for the next word.
        if (load_valid && !shadow_full_q) begin
            shadow_d      = load_data;
            shadow_full_d = 1'b1;
        end

        if (state_d == StIdle) begin
            dout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            rx_data_q     <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            dout_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            rx_data_q     <= rx_data_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            dout_q        <= dout_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            aborted_q     <= aborted_d;
        end
    end

    assign dout       = dout_q;
    assign load_ready = !shadow_full_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = (state_q == StActive);
    assign underrun   = underrun_q;
    assign aborted    = aborted_q;

endmodule
